// File: rtl/hw_barrier_pkg.sv
// Shared register map and config-port decode for the hardware barrier array.
package hw_barrier_pkg;

  localparam logic [1:0] REG_PART_MASK = 2'd0;
  localparam logic [1:0] REG_TGT_MASK  = 2'd1;
  localparam logic [1:0] REG_STATUS    = 2'd2;
  localparam logic [1:0] REG_GEN       = 2'd3;

  localparam int ERR_BIT      = 31;
  localparam int ADDR_IDX_LSB = 4;
  localparam int ADDR_IDX_W   = 4;
  localparam int ADDR_REG_LSB = 2;
  localparam int ADDR_REG_W   = 2;

  typedef struct packed {
    logic                  wr;
    logic                  rd;
    logic [ADDR_IDX_W-1:0] idx;
    logic [ADDR_REG_W-1:0] sel;
  } cfg_dec_t;

  // Note the inverted wen sense on this bus: 1 means read.
  function automatic cfg_dec_t cfg_decode(logic req, logic wen, logic [7:0] addr);
    cfg_dec_t d;
    d.wr  = req & ~wen;
    d.rd  = req & wen;
    d.idx = addr[ADDR_IDX_LSB +: ADDR_IDX_W];
    d.sel = addr[ADDR_REG_LSB +: ADDR_REG_W];
    return d;
  endfunction

endpackage

// File: rtl/hw_barrier_slice.sv
// One barrier: participant/target masks, arrival status, generation counter,
// sticky error flag and the one-cycle completion pulse.
module hw_barrier_slice
  import hw_barrier_pkg::*;
#(
  parameter int NB_CORES = 8,
  parameter int GEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NB_CORES-1:0] arrive,
  input  logic                part_we,
  input  logic                tgt_we,
  input  logic                err_clr,
  input  logic [NB_CORES-1:0] wmask,
  output logic [NB_CORES-1:0] part_mask,
  output logic [NB_CORES-1:0] tgt_mask,
  output logic [NB_CORES-1:0] status,
  output logic [GEN_W-1:0]    gen,
  output logic                err,
  output logic [NB_CORES-1:0] event_vec,
  output logic                done
);

  logic [NB_CORES-1:0] accept, reject, merged;
  logic                complete;

  // Anything not a fresh participant is rejected; with PART_MASK=0 that is every arrival.
  assign accept   = arrive & part_mask & ~status;
  assign reject   = arrive & ~accept;
  assign merged   = status | accept;
  assign complete = (|part_mask) && (merged == part_mask) && !part_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_mask <= '0;
      tgt_mask  <= '0;
      status    <= '0;
      gen       <= '0;
      err       <= 1'b0;
      event_vec <= '0;
      done      <= 1'b0;
    end else begin
      event_vec <= '0;
      done      <= 1'b0;
      // A mask rewrite aborts the generation and beats a simultaneous completion.
      if (part_we) begin
        part_mask <= wmask;
        status    <= '0;
      end else if (complete) begin
        status    <= '0;
        gen       <= gen + GEN_W'(1);
        event_vec <= tgt_mask;
        done      <= 1'b1;
      end else begin
        status    <= merged;
      end
      if (tgt_we) tgt_mask <= wmask;
      if (|reject)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: rtl/hw_barrier_array.sv
// Array of hardware barriers: config decode, arrival fan-out per barrier
// and registered read-back mux.
module hw_barrier_array
  import hw_barrier_pkg::*;
#(
  parameter  int NB_CORES = 8,
  parameter  int NB_BARR  = 8,
  parameter  int GEN_W    = 8,
  localparam int ID_W     = (NB_BARR > 1) ? $clog2(NB_BARR) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_CORES-1:0]              arrive_valid_i,
  input  logic [NB_CORES-1:0][ID_W-1:0]    arrive_id_i,
  output logic [NB_BARR-1:0][NB_CORES-1:0] barrier_event_o,
  output logic [NB_BARR-1:0]               barrier_done_o,
  input  logic                             cfg_req_i,
  output logic                             cfg_gnt_o,
  input  logic [7:0]                       cfg_addr_i,
  input  logic                             cfg_wen_i,
  input  logic [31:0]                      cfg_wdata_i,
  output logic                             cfg_r_valid_o,
  output logic [31:0]                      cfg_r_rdata_o
);

  cfg_dec_t                        dec;
  logic [NB_BARR-1:0][NB_CORES-1:0] part_q, tgt_q, status_q;
  logic [NB_BARR-1:0][GEN_W-1:0]    gen_q;
  logic [NB_BARR-1:0]               err_q;
  logic [31:0]                      rd_mux;
  logic                             unused_cfg;

  assign dec        = cfg_decode(cfg_req_i, cfg_wen_i, cfg_addr_i);
  assign cfg_gnt_o  = cfg_req_i;
  assign unused_cfg = ^{cfg_addr_i[1:0], cfg_wdata_i};

  // Indices past NB_BARR never match a slice, so such writes fall away naturally.
  for (genvar b = 0; b < NB_BARR; b++) begin : g_barr
    logic [NB_CORES-1:0] arr;
    logic                hit;

    assign hit = dec.wr && (dec.idx == ADDR_IDX_W'(b));

    always_comb begin
      arr = '0;
      for (int c = 0; c < NB_CORES; c++)
        arr[c] = arrive_valid_i[c] && (arrive_id_i[c] == ID_W'(b));
    end

    hw_barrier_slice #(
      .NB_CORES (NB_CORES),
      .GEN_W    (GEN_W)
    ) u_slice (
      .clk       (clk_i),
      .rst       (rst_i),
      .arrive    (arr),
      .part_we   (hit && dec.sel == REG_PART_MASK),
      .tgt_we    (hit && dec.sel == REG_TGT_MASK),
      .err_clr   (hit && dec.sel == REG_GEN && cfg_wdata_i[ERR_BIT]),
      .wmask     (cfg_wdata_i[NB_CORES-1:0]),
      .part_mask (part_q[b]),
      .tgt_mask  (tgt_q[b]),
      .status    (status_q[b]),
      .gen       (gen_q[b]),
      .err       (err_q[b]),
      .event_vec (barrier_event_o[b]),
      .done      (barrier_done_o[b])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NB_BARR; b++) begin
      if (dec.idx == ADDR_IDX_W'(b)) begin
        case (dec.sel)
          REG_PART_MASK: rd_mux = 32'(part_q[b]);
          REG_TGT_MASK:  rd_mux = 32'(tgt_q[b]);
          REG_STATUS:    rd_mux = 32'(status_q[b]);
          default: begin
            rd_mux          = 32'(gen_q[b]);
            rd_mux[ERR_BIT] = err_q[b];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_r_valid_o <= 1'b0;
      cfg_r_rdata_o <= '0;
    end else begin
      cfg_r_valid_o <= cfg_req_i;
      cfg_r_rdata_o <= dec.rd ? rd_mux : '0;
    end
  end

endmodule

// File: doc/hw_barrier_array.md
HW_BARRIER_ARRAY -- requirements
Module: hw_barrier_array

Interface
REQ-001 SHALL have parameter NB_CORES, default 8, number of cores (2..32).
REQ-002 SHALL have parameter NB_BARR, default 8, number of barriers (1..16).
REQ-003 SHALL have parameter GEN_W, default 8, generation counter width (1..23).
REQ-004 SHALL have port clk_i  in  1  single clock.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port arrive_valid_i  in  NB_CORES  per-core arrival strobe.
REQ-007 SHALL have port arrive_id_i  in  NB_CORES x clog2(NB_BARR)  per-core target barrier index.
REQ-008 SHALL have port barrier_event_o  out  NB_BARR x NB_CORES  per-barrier completion pulse, as target-core vector.
REQ-009 SHALL have port barrier_done_o  out  NB_BARR  one-cycle completion strobe per barrier.
REQ-010 SHALL have port cfg_req_i  in  1  config request.
REQ-011 SHALL have port cfg_gnt_o  out  1  grant.
REQ-012 SHALL have port cfg_addr_i  in  8  byte address.
REQ-013 SHALL have port cfg_wen_i  in  1  1 = read, 0 = write.
REQ-014 SHALL have port cfg_wdata_i  in  32  write data.
REQ-015 SHALL have port cfg_r_valid_o  out  1  response valid.
REQ-016 SHALL have port cfg_r_rdata_o  out  32  read data.

Function
REQ-017 SHALL decode addr[7:4] as barrier index and addr[3:2] as register: 0 PART_MASK (rw), 1 TGT_MASK (rw), 2 STATUS (ro, arrived bits), 3 GEN (ro [GEN_W-1:0], bit 31 sticky ERR, W1C).
REQ-018 SHALL drive cfg_gnt_o = cfg_req_i combinationally and assert cfg_r_valid_o exactly one cycle after every granted request, reads and writes alike.
REQ-019 SHALL return read data registered, zero-extended; an index >= NB_BARR SHALL read 0 and ignore writes.
REQ-020 SHALL set STATUS[c] of barrier arrive_id_i[c] on each cycle with arrive_valid_i[c]=1.
REQ-021 SHALL accept arrivals from any number of cores to the same or different barriers in one cycle.
REQ-022 SHALL declare completion when PART_MASK != 0 and (STATUS | this-cycle arrivals) & PART_MASK == PART_MASK.
REQ-023 On completion in cycle N, barrier SHALL, at edge N+1, drive barrier_event_o[b] = TGT_MASK and barrier_done_o[b]=1 for exactly one cycle, clear STATUS, and increment GEN modulo 2^GEN_W.
REQ-024 Arrivals in cycle N+1 SHALL count toward the next generation.
REQ-025 An arrival from a core already set in STATUS, from a core not in PART_MASK, or to a barrier with PART_MASK=0 SHALL be ignored and SHALL set ERR.
REQ-026 A write to PART_MASK SHALL clear STATUS (abort), with no event; if it coincides with a completing arrival, the write SHALL win and no event SHALL be emitted.
REQ-027 A write of 1 to GEN bit 31 SHALL clear ERR; an error in the same cycle SHALL win (ERR stays 1).
REQ-028 An arrive_id_i >= NB_BARR SHALL be ignored without error.

Reset
REQ-029 On rst_i=1, asynchronously: PART_MASK, TGT_MASK, STATUS, GEN, ERR = 0; barrier_event_o, barrier_done_o, cfg_r_valid_o, cfg_r_rdata_o = 0.
REQ-030 Reset mid-barrier SHALL discard partial arrivals; no event SHALL be emitted on reset release.

Structure
REQ-031 Package hw_barrier_pkg SHALL hold register offsets (PART_MASK, TGT_MASK, STATUS, GEN), ERR bit position, and the address-field constants.
REQ-032 Per-barrier state and completion logic SHALL be a sub-module hw_barrier_slice, instantiated NB_BARR times; the top SHALL hold decode, arrival fan-out, and read mux.

Verification
REQ-033 Config PART=0xFF, TGT=0x0F on barrier 2; cores 0..7 arrive on separate cycles -> one cycle after core 7, barrier_event_o[2]=0x0F, done[2]=1 for one cycle, GEN=1, STATUS=0.
REQ-034 PART=0x03 on barrier 0; cores 0 and 1 arrive in the same cycle -> event next cycle; core 0 arrives again the next cycle -> STATUS=0x01, no ERR.
REQ-035 PART=0x03; core 0 arrives twice before core 1 -> ERR=1, STATUS=0x01; write GEN=0x80000000 -> ERR=0.
REQ-036 PART=0x0F, cores 0..2 arrived; core 3 arrives in the same cycle as a PART_MASK write of 0x0F -> no event, STATUS=0, GEN unchanged.
REQ-037 GEN_W=2; complete barrier 1 five times -> GEN reads 1; a read at addr 0xF0 with NB_BARR=8 -> rdata 0, r_valid one cycle later.
REQ-038 Assert rst_i with 3 of 4 cores arrived -> all registers and outputs 0 immediately; no event after release.
